// File: rtl/range_stream_source.sv
// Framed burst source: buffers up to DEPTH samples, then replays them with go/finish strobes.
// Optional running min/max tracking under `RANGE_STREAM_SOURCE_EXPECT_EN drives expected_range.
module range_stream_source #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       clear,
  input  logic                       start,
  output logic [WIDTH-1:0]           data_out,
  output logic                       go,
  output logic                       finish,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       error,
  output logic [WIDTH-1:0]           expected_range,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [AW-1:0]    r_idx;
  logic [CW-1:0]    r_count;
  logic             r_error;
  logic [WIDTH-1:0] r_data;
  logic             r_go;
  logic             r_finish;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_idle;
  logic w_full;
  logic w_wr_accept;
  logic w_last;

  assign w_idle      = (r_state == IDLE);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_wr_accept = w_idle && !clear && !start && wr_en && !w_full;
  assign w_last      = ({1'b0, r_idx} == (r_count - CW'(1)));

  // Buffer has no reset: contents only matter below r_count.
  always_ff @(posedge clock) begin
    if (w_wr_accept) r_mem[r_count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
      r_data   <= '0;
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_count <= '0;
            r_error <= 1'b0;
          end else if (start) begin
            if (r_count >= CW'(2)) begin
              r_state <= SEND;
              r_idx   <= '0;
              if (wr_en) r_error <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end else if (wr_en) begin
            if (w_full) r_error <= 1'b1;
            else        r_count <= r_count + CW'(1);
          end
        end
        SEND: begin
          if (wr_en || clear) r_error <= 1'b1;
          r_data   <= r_mem[r_idx];
          r_go     <= (r_idx == '0);
          r_finish <= w_last;
          r_busy   <= 1'b1;
          r_idx    <= r_idx + AW'(1);
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          if (wr_en || clear) r_error <= 1'b1;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RANGE_STREAM_SOURCE_EXPECT_EN
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_range;
  logic [WIDTH-1:0] w_new_min;
  logic [WIDTH-1:0] w_new_max;

  // An empty buffer means the incoming sample seeds both extremes.
  assign w_new_min = ((r_count == '0) || (wr_data < r_min)) ? wr_data : r_min;
  assign w_new_max = ((r_count == '0) || (wr_data > r_max)) ? wr_data : r_max;

  always_ff @(posedge clock) begin
    if (reset || (w_idle && clear)) begin
      r_min   <= '0;
      r_max   <= '0;
      r_range <= '0;
    end else if (w_wr_accept) begin
      r_min   <= w_new_min;
      r_max   <= w_new_max;
      r_range <= w_new_max - w_new_min;
    end
  end

  assign expected_range = r_range;
`else
  assign expected_range = '0;
`endif

  assign data_out  = r_data;
  assign go        = r_go;
  assign finish    = r_finish;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_range_stream_source.sv
// Directed bench for range_stream_source: load, burst, replay, misuse and mid-burst reset.
module tb_range_stream_source;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clock;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clear;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             done;
  logic [4:0]       count;
  logic             error;
  logic [WIDTH-1:0] expected_range;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] first_vals[4];

  range_stream_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .clear(clear), .start(start), .data_out(data_out), .go(go),
    .finish(finish), .busy(busy), .done(done), .count(count),
    .error(error), .expected_range(expected_range), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [WIDTH-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Launches a burst and checks it against exp_q; disturb pokes wr_en and clear mid-burst.
  task automatic burst(input string tag, input bit disturb);
    int n;
    logic [WIDTH-1:0] e;
    n = exp_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_start_go"}, go, 0);
    check({tag, "_start_busy"}, busy, 0);
    for (int i = 0; i < n; i++) begin
      if (disturb && i == 1) begin wr_en = 1'b1; wr_data = 8'd99; end
      if (disturb && i == 3) clear = 1'b1;
      step();
      wr_en = 1'b0;
      clear = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s_data%0d", tag, i), data_out, e);
      check($sformatf("%s_go%0d", tag, i), go, (i == 0));
      check($sformatf("%s_fin%0d", tag, i), finish, (i == n - 1));
      check($sformatf("%s_busy%0d", tag, i), busy, 1);
    end
    step();
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_data"}, data_out, 0);
    check({tag, "_done_fin"}, finish, 0);
    step();
    check({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_data", data_out, 0);
    check("rst_go", go, 0);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_error", error, 0);
    check("rst_range", expected_range, 0);

    // Basic 4-sample frame, then an identical replay.
    first_vals = '{8'd5, 8'd20, 8'd3, 8'd9};
    write(8'd5);
`ifdef RANGE_STREAM_SOURCE_EXPECT_EN
    check("range_one", expected_range, 0);
`endif
    write(8'd20);
    write(8'd3);
    write(8'd9);
    check("t1_count", count, 4);
`ifdef RANGE_STREAM_SOURCE_EXPECT_EN
    check("t1_range", expected_range, 17);
`else
    check("t1_range", expected_range, 0);
`endif
    foreach (first_vals[i]) exp_q.push_back(first_vals[i]);
    burst("t1", 1'b0);
    check("t1_count_after", count, 4);
    check("t1_error", error, 0);
    foreach (first_vals[i]) exp_q.push_back(first_vals[i]);
    burst("replay", 1'b0);
    check("replay_count", count, 4);

    // Single sample cannot be launched.
    do_clear();
    check("t2_clear_count", count, 0);
    write(8'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_error", error, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t2_go%0d", i), go, 0);
      check($sformatf("t2_fin%0d", i), finish, 0);
      check($sformatf("t2_busy%0d", i), busy, 0);
    end
    do_clear();
    check("t2_err_cleared", error, 0);
    check("t2_count_cleared", count, 0);
    check("t2_range_cleared", expected_range, 0);

    // Fill to capacity, overflow write is dropped.
    for (int i = 0; i < DEPTH; i++) write(WIDTH'(i));
    check("t3_count_full", count, 16);
    check("t3_err_before", error, 0);
    write(8'd99);
    check("t3_count_ovf", count, 16);
    check("t3_err_ovf", error, 1);
`ifdef RANGE_STREAM_SOURCE_EXPECT_EN
    check("t3_range", expected_range, 15);
`endif
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(WIDTH'(i));
    burst("t3", 1'b0);
    check("t3_err_sticky", error, 1);

    // Misuse during SEND must not disturb the frame.
    do_clear();
    for (int i = 0; i < 8; i++) write(WIDTH'(i * 3 + 1));
    check("t4_err_pre", error, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(WIDTH'(i * 3 + 1));
    burst("t4", 1'b1);
    check("t4_err", error, 1);
    check("t4_count", count, 8);

    // Reset three cycles into a 10-sample burst.
    do_clear();
    for (int i = 0; i < 10; i++) write(WIDTH'(8'h40 + i));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5_go", go, 1);
    check("t5_data0", data_out, 8'h40);
    step();
    step();
    check("t5_data2", data_out, 8'h42);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_go_rst", go, 0);
    check("t5_fin_rst", finish, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_data_rst", data_out, 0);
    check("t5_count_rst", count, 0);
    check("t5_range_rst", expected_range, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("t5_nodone%0d", i), done, 0);
      check($sformatf("t5_nofin%0d", i), finish, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
